// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : seg_scan_ctrl
// Purpose : Time-multiplexes one shared 4-bit-to-7-segment decoder across
//           four registered hex digit outputs. It has a one-deep pending
//           slot for loads that arrive while a scan is running.
// Option  : SEG_LZ_SUPPRESS_EN - when defined, leading zero digits 3..1
//           are blanked.
// Revision: 1.0 - initial release
// ============================================================================
module seg_scan_ctrl #(
  parameter int INVERT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] value,
  input  logic [3:0]  blank_mask,
  output logic [3:0]  dec_code,
  input  logic [6:0]  dec_seg,
  output logic [6:0]  hex0,
  output logic [6:0]  hex1,
  output logic [6:0]  hex2,
  output logic [6:0]  hex3,
  output logic        busy,
  output logic        done
);

  localparam logic [6:0] C_BLANK = (INVERT != 0) ? 7'h7F : 7'h00;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            w_start;
  logic [1:0]      r_idx;
  logic [15:0]     r_work_val;
  logic [3:0]      r_work_mask;
  logic [15:0]     r_pend_val;
  logic [3:0]      r_pend_mask;
  logic            r_pend;
  logic [15:0]     w_start_val;
  logic [3:0]      w_start_mask;
  logic [3:0]      w_digit;
  logic [3:0]      w_lz;
  logic            w_blank;
  logic [6:0]      w_seg;
  logic [3:0][6:0] r_hex;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (load) begin
          w_state_nxt = ST_SCAN;
          w_start     = 1'b1;
        end
      end
      ST_SCAN: begin
        if (r_idx == 2'd3) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        // Back-to-back restart avoids an idle gap between queued values
        if (load || r_pend) begin
          w_state_nxt = ST_SCAN;
          w_start     = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // An incoming load always beats the pending slot
  assign w_start_val  = load ? value      : r_pend_val;
  assign w_start_mask = load ? blank_mask : r_pend_mask;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_work_val  <= 16'h0000;
      r_work_mask <= 4'h0;
      r_idx       <= 2'd0;
    end else if (w_start) begin
      r_work_val  <= w_start_val;
      r_work_mask <= w_start_mask;
      r_idx       <= 2'd0;
    end else if (r_state == ST_SCAN) begin
      r_idx       <= r_idx + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pend      <= 1'b0;
      r_pend_val  <= 16'h0000;
      r_pend_mask <= 4'h0;
    end else if ((r_state == ST_SCAN) && load) begin
      r_pend      <= 1'b1;
      r_pend_val  <= value;
      r_pend_mask <= blank_mask;
    end else if (r_state == ST_DONE) begin
      r_pend      <= 1'b0;
    end
  end

`ifdef SEG_LZ_SUPPRESS_EN
  assign w_lz[3] = (r_work_val[15:12] == 4'h0);
  assign w_lz[2] = w_lz[3] && (r_work_val[11:8] == 4'h0);
  assign w_lz[1] = w_lz[2] && (r_work_val[7:4] == 4'h0);
  assign w_lz[0] = 1'b0;
`else
  assign w_lz = 4'b0000;
`endif

  assign w_digit  = r_work_val[{r_idx, 2'b00} +: 4];
  assign w_blank  = r_work_mask[r_idx] | w_lz[r_idx];
  assign w_seg    = w_blank ? C_BLANK : dec_seg;
  assign dec_code = (r_state == ST_SCAN) ? w_digit : 4'h0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hex <= {4{C_BLANK}};
    end else if (r_state == ST_SCAN) begin
      r_hex[r_idx] <= w_seg;
    end
  end

  assign hex0 = r_hex[0];
  assign hex1 = r_hex[1];
  assign hex2 = r_hex[2];
  assign hex3 = r_hex[3];
  assign busy = (r_state != ST_IDLE);
  assign done = (r_state == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_seg_scan_ctrl
// Purpose : Self-checking bench for seg_scan_ctrl (vector table, directed
//           back-to-back sequence, randomized run against a reference model)
// Revision: 1.0 - initial release
// ============================================================================
module tb_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load;
  logic [15:0] value;
  logic [3:0]  blank_mask;
  logic [3:0]  dec_code;
  logic [6:0]  dec_seg;
  logic [6:0]  hex0, hex1, hex2, hex3;
  logic        busy, done;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

`ifdef SEG_LZ_SUPPRESS_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif
  localparam logic [6:0] H3_02A0 = LZ ? 7'h7F : 7'h40;

  function automatic logic [6:0] seg7(input logic [3:0] c);
    case (c)
      4'h0: seg7 = 7'h40; 4'h1: seg7 = 7'h79; 4'h2: seg7 = 7'h24; 4'h3: seg7 = 7'h30;
      4'h4: seg7 = 7'h19; 4'h5: seg7 = 7'h12; 4'h6: seg7 = 7'h02; 4'h7: seg7 = 7'h78;
      4'h8: seg7 = 7'h00; 4'h9: seg7 = 7'h10; 4'hA: seg7 = 7'h08; 4'hB: seg7 = 7'h03;
      4'hC: seg7 = 7'h46; 4'hD: seg7 = 7'h21; 4'hE: seg7 = 7'h06; default: seg7 = 7'h0E;
    endcase
  endfunction

  assign dec_seg = seg7(dec_code);

  seg_scan_ctrl #(.INVERT(1)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .value(value), .blank_mask(blank_mask),
    .dec_code(dec_code), .dec_seg(dec_seg),
    .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3),
    .busy(busy), .done(done)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst_n;
    logic        load;
    logic [15:0] value;
    logic [3:0]  mask;
    logic        busy;
    logic        done;
    logic [3:0]  code;
    logic [6:0]  h0, h1, h2, h3;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic l, input logic [15:0] v,
                              input logic [3:0] m, input logic b, input logic d,
                              input logic [3:0] c, input logic [6:0] a0,
                              input logic [6:0] a1, input logic [6:0] a2,
                              input logic [6:0] a3);
    mk = '{r, l, v, m, b, d, c, a0, a1, a2, a3};
  endfunction

  vec_t vecs [20];

  // Reference model: pos counts cycles into a scan (0 = no scan, 5 = done cycle)
  int          pos;
  logic [15:0] wv;
  logic [3:0]  wm;
  logic [15:0] pq_v[$];
  logic [3:0]  pq_m[$];
  logic [6:0]  mh [4];

  function automatic logic [3:0] nib(input logic [15:0] v, input int d);
    nib = 4'((v >> (4 * d)) & 16'h000F);
  endfunction

  function automatic bit digit_blank(input int d);
    digit_blank = wm[d] || (LZ && d > 0 && (wv >> (4 * d)) == 16'h0000);
  endfunction

  task automatic model_step();
    int d;
    if (!rst_n) begin
      pos = 0;
      pq_v.delete();
      pq_m.delete();
      for (int i = 0; i < 4; i++) mh[i] = 7'h7F;
    end else if (pos == 0) begin
      if (load) begin
        wv = value; wm = blank_mask; pos = 1;
      end
    end else if (pos < 5) begin
      d = pos - 1;
      mh[d] = digit_blank(d) ? 7'h7F : seg7(nib(wv, d));
      if (load) begin
        pq_v.delete(); pq_m.delete();
        pq_v.push_back(value); pq_m.push_back(blank_mask);
      end
      pos++;
    end else begin
      if (load) begin
        wv = value; wm = blank_mask; pos = 1;
        pq_v.delete(); pq_m.delete();
      end else if (pq_v.size() != 0) begin
        wv = pq_v.pop_front(); wm = pq_m.pop_front(); pos = 1;
      end else begin
        pos = 0;
      end
    end
  endtask

  int ndone;

  initial begin
    rst_n = 1'b0; load = 1'b0; value = 16'h0000; blank_mask = 4'h0;

    vecs[0]  = mk(0, 1, 16'hFFFF, 4'h0, 0, 0, 4'h0, 7'h7F, 7'h7F, 7'h7F, 7'h7F);
    vecs[1]  = mk(1, 0, 16'h0000, 4'h0, 0, 0, 4'h0, 7'h7F, 7'h7F, 7'h7F, 7'h7F);
    vecs[2]  = mk(1, 1, 16'h02A0, 4'h0, 1, 0, 4'h0, 7'h7F, 7'h7F, 7'h7F, 7'h7F);
    vecs[3]  = mk(1, 0, 16'h0000, 4'h0, 1, 0, 4'hA, 7'h40, 7'h7F, 7'h7F, 7'h7F);
    vecs[4]  = mk(1, 0, 16'h0000, 4'h0, 1, 0, 4'h2, 7'h40, 7'h08, 7'h7F, 7'h7F);
    vecs[5]  = mk(1, 0, 16'h0000, 4'h0, 1, 0, 4'h0, 7'h40, 7'h08, 7'h24, 7'h7F);
    vecs[6]  = mk(1, 0, 16'h0000, 4'h0, 1, 1, 4'h0, 7'h40, 7'h08, 7'h24, H3_02A0);
    vecs[7]  = mk(1, 0, 16'h0000, 4'h0, 0, 0, 4'h0, 7'h40, 7'h08, 7'h24, H3_02A0);
    vecs[8]  = mk(1, 1, 16'h1111, 4'h5, 1, 0, 4'h1, 7'h40, 7'h08, 7'h24, H3_02A0);
    vecs[9]  = mk(1, 0, 16'h0000, 4'h0, 1, 0, 4'h1, 7'h7F, 7'h08, 7'h24, H3_02A0);
    vecs[10] = mk(1, 0, 16'h0000, 4'h0, 1, 0, 4'h1, 7'h7F, 7'h79, 7'h24, H3_02A0);
    vecs[11] = mk(1, 0, 16'h0000, 4'h0, 1, 0, 4'h1, 7'h7F, 7'h79, 7'h7F, H3_02A0);
    vecs[12] = mk(1, 0, 16'h0000, 4'h0, 1, 1, 4'h0, 7'h7F, 7'h79, 7'h7F, 7'h79);
    vecs[13] = mk(1, 0, 16'h0000, 4'h0, 0, 0, 4'h0, 7'h7F, 7'h79, 7'h7F, 7'h79);
    vecs[14] = mk(1, 1, 16'h1234, 4'h0, 1, 0, 4'h4, 7'h7F, 7'h79, 7'h7F, 7'h79);
    vecs[15] = mk(1, 1, 16'h5555, 4'h0, 1, 0, 4'h3, 7'h19, 7'h79, 7'h7F, 7'h79);
    vecs[16] = mk(1, 0, 16'h0000, 4'h0, 1, 0, 4'h2, 7'h19, 7'h30, 7'h7F, 7'h79);
    vecs[17] = mk(0, 1, 16'h9999, 4'h0, 0, 0, 4'h0, 7'h7F, 7'h7F, 7'h7F, 7'h7F);
    vecs[18] = mk(1, 0, 16'h0000, 4'h0, 0, 0, 4'h0, 7'h7F, 7'h7F, 7'h7F, 7'h7F);
    vecs[19] = mk(1, 0, 16'h0000, 4'h0, 0, 0, 4'h0, 7'h7F, 7'h7F, 7'h7F, 7'h7F);

    for (int i = 0; i < 20; i++) begin
      rst_n = vecs[i].rst_n; load = vecs[i].load;
      value = vecs[i].value; blank_mask = vecs[i].mask;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("v%0d busy", i), 16'(busy), 16'(vecs[i].busy));
      chk($sformatf("v%0d done", i), 16'(done), 16'(vecs[i].done));
      chk($sformatf("v%0d dec_code", i), 16'(dec_code), 16'(vecs[i].code));
      chk($sformatf("v%0d hex0", i), 16'(hex0), 16'(vecs[i].h0));
      chk($sformatf("v%0d hex1", i), 16'(hex1), 16'(vecs[i].h1));
      chk($sformatf("v%0d hex2", i), 16'(hex2), 16'(vecs[i].h2));
      chk($sformatf("v%0d hex3", i), 16'(hex3), 16'(vecs[i].h3));
    end

    // Back-to-back: pending slot overwritten, second scan follows DONE directly
    rst_n = 1'b1; load = 1'b1; value = 16'h0000; blank_mask = 4'h0;
    @(posedge clk);
    @(negedge clk);
    ndone = 0;
    for (int k = 1; k <= 11; k++) begin
      chk($sformatf("b2b busy t+%0d", k), 16'(busy), 16'(k <= 10));
      chk($sformatf("b2b done t+%0d", k), 16'(done), 16'(k == 5 || k == 10));
      if (done) ndone++;
      load  = (k == 2 || k == 3);
      value = (k == 2) ? 16'h2222 : 16'hAAAA;
      @(posedge clk);
      @(negedge clk);
    end
    load = 1'b0;
    chk("b2b done count", 16'(ndone), 16'd2);
    chk("b2b hex0", 16'(hex0), 16'h0008);
    chk("b2b hex1", 16'(hex1), 16'h0008);
    chk("b2b hex2", 16'(hex2), 16'h0008);
    chk("b2b hex3", 16'(hex3), 16'h0008);

    // Randomized run against the reference model
    rst_n = 1'b0;
    @(posedge clk);
    model_step();
    @(negedge clk);
    for (int n = 0; n < 600; n++) begin
      rst_n      = ($urandom_range(0, 39) != 0);
      load       = ($urandom_range(0, 2) == 0);
      value      = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
      blank_mask = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      @(posedge clk);
      model_step();
      @(negedge clk);
      chk("rnd busy", 16'(busy), 16'(pos != 0));
      chk("rnd done", 16'(done), 16'(pos == 5));
      chk("rnd dec_code", 16'(dec_code), (pos >= 1 && pos <= 4) ? 16'(nib(wv, pos - 1)) : 16'h0);
      chk("rnd hex0", 16'(hex0), 16'(mh[0]));
      chk("rnd hex1", 16'(hex1), 16'(mh[1]));
      chk("rnd hex2", 16'(hex2), 16'(mh[2]));
      chk("rnd hex3", 16'(hex3), 16'(mh[3]));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
